// File: rtl/softmax_engine.sv
// Sequential softmax/argmax engine: one class per cycle for max search and
// exponent approximation, then a restoring divider normalises each class.
module softmax_engine #(
    parameter int N_CLASSES = 10,
    parameter int DW        = 16,
    parameter int FRAC      = 12,
    parameter int IDXW      = $clog2(N_CLASSES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CLASSES*DW-1:0] logits,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    argmax_mode,
    output logic [N_CLASSES*DW-1:0] softmax_out,
    output logic [IDXW-1:0]         argmax_idx,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int EW = FRAC + 1;
    localparam int SW = FRAC + 1 + IDXW;
    localparam int CW = $clog2(DW + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAX  = 3'd1;
    localparam logic [2:0] S_EXP  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic [DW-1:0]        QMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW:0]   DMIN = (DW+1)'(-(2 ** (FRAC + 1)));
    localparam logic signed [DW:0]   ONE  = (DW+1)'(2 ** FRAC);

    logic [2:0]              state_q, state_d;
    logic [N_CLASSES*DW-1:0] logits_q;
    logic                    mode_q;
    logic [IDXW-1:0]         idx_q;
    logic signed [DW-1:0]    max_q;
    logic [IDXW-1:0]         argmax_q;
    logic [EW-1:0]           e_q [N_CLASSES];
    logic [SW-1:0]           sum_q;
    logic [SW-1:0]           rem_q;
    logic [DW-1:0]           quo_q;
    logic [CW-1:0]           cnt_q;
    logic [N_CLASSES*DW-1:0] prob_q;
    logic                    valid_q;

    logic                    last;
    logic signed [DW-1:0]    cur;
    logic signed [DW:0]      d;
    logic signed [DW:0]      hd;
    logic [EW-1:0]           h;
    logic [2*EW-1:0]         hsq;
    logic [EW-1:0]           e_new;
    logic [SW:0]             trial;
    logic [SW:0]             trial_sub;
    logic                    ge;
    logic [DW-1:0]           q_fin;
    logic [DW-1:0]           q_sat;
    logic                    unused_bits;

    assign last = (idx_q == IDXW'(N_CLASSES - 1));

    // e = ((1 + d/2)^2) approximation of exp(d), clamped to zero far below the max
    always_comb begin
        cur       = $signed(logits_q[int'(idx_q)*DW +: DW]);
        d         = $signed({cur[DW-1], cur}) - $signed({max_q[DW-1], max_q});
        hd        = ONE + (d >>> 1);
        h         = (d < DMIN) ? '0 : hd[EW-1:0];
        hsq       = (2*EW)'(h) * (2*EW)'(h);
        e_new     = hsq[FRAC +: EW];
        trial     = {rem_q, quo_q[DW-1]};
        ge        = (trial >= {1'b0, sum_q});
        trial_sub = trial - {1'b0, sum_q};
        q_fin     = {quo_q[DW-2:0], ge};
        q_sat     = q_fin[DW-1] ? QMAX : q_fin;
    end

    assign unused_bits = ^{hd[DW:EW], hsq[FRAC-1:0], hsq[2*EW-1], trial_sub[SW]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_MAX;
            S_MAX:  if (last) state_d = mode_q ? S_OUT : S_EXP;
            S_EXP:  if (last) state_d = S_DIV;
            S_DIV:  if (cnt_q == CW'(DW) && last) state_d = S_OUT;
            S_OUT:  if (valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            logits_q <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            max_q    <= '0;
            argmax_q <= '0;
            sum_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            prob_q   <= '0;
            valid_q  <= 1'b0;
            for (int unsigned i = 0; i < N_CLASSES; i++) e_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        logits_q <= logits;
                        mode_q   <= argmax_mode;
                        idx_q    <= '0;
                        sum_q    <= '0;
                    end
                end
                S_MAX: begin
                    if (idx_q == '0 || cur > max_q) begin
                        max_q    <= cur;
                        argmax_q <= idx_q;
                    end
                    idx_q <= last ? '0 : idx_q + IDXW'(1);
                end
                S_EXP: begin
                    e_q[idx_q] <= e_new;
                    sum_q      <= sum_q + SW'(e_new);
                    idx_q      <= last ? '0 : idx_q + IDXW'(1);
                    cnt_q      <= '0;
                end
                S_DIV: begin
                    if (cnt_q == '0) begin
                        // numerator e<<(DW-1): high part seeds the remainder, low DW bits shift in
                        rem_q <= SW'(e_q[idx_q] >> 1);
                        quo_q <= {e_q[idx_q][0], {(DW-1){1'b0}}};
                        cnt_q <= CW'(1);
                    end else begin
                        rem_q <= ge ? trial_sub[SW-1:0] : trial[SW-1:0];
                        quo_q <= q_fin;
                        if (cnt_q == CW'(DW)) begin
                            prob_q[int'(idx_q)*DW +: DW] <= q_sat;
                            cnt_q <= '0;
                            idx_q <= last ? '0 : idx_q + IDXW'(1);
                            if (last) valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (!valid_q) begin
                        for (int unsigned i = 0; i < N_CLASSES; i++)
                            prob_q[i*DW +: DW] <= (IDXW'(i) == argmax_q) ? QMAX : '0;
                        valid_q <= 1'b1;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = valid_q;
    assign softmax_out = prob_q;
    assign argmax_idx  = argmax_q;

endmodule

// File: tb/tb_softmax_engine.sv
// Randomised and directed bench for softmax_engine against an arithmetic reference model.
module tb_softmax_engine;

    localparam int N    = 10;
    localparam int DW   = 16;
    localparam int FRAC = 12;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N*DW-1:0] logits = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            argmax_mode = 1'b0;
    logic [N*DW-1:0] softmax_out;
    logic [IDXW-1:0] argmax_idx;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int lg [N];
    int exp_p [N];
    int exp_i;

    softmax_engine #(.N_CLASSES(N), .DW(DW), .FRAC(FRAC), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n), .logits(logits), .in_valid(in_valid),
        .in_ready(in_ready), .argmax_mode(argmax_mode), .softmax_out(softmax_out),
        .argmax_idx(argmax_idx), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    // Reference: softmax via (1+d/2)^2 exponent approximation and truncating division
    function automatic void model(input bit m);
        int mx, sum, d, h, q;
        int e [N];
        mx = lg[0];
        exp_i = 0;
        for (int i = 1; i < N; i++)
            if (lg[i] > mx) begin mx = lg[i]; exp_i = i; end
        if (m) begin
            for (int i = 0; i < N; i++) exp_p[i] = (i == exp_i) ? 32767 : 0;
        end else begin
            sum = 0;
            for (int i = 0; i < N; i++) begin
                d = lg[i] - mx;
                if (d < -(1 << (FRAC + 1))) e[i] = 0;
                else begin
                    h = (1 << FRAC) + (d >>> 1);
                    e[i] = (h * h) / (1 << FRAC);
                end
                sum += e[i];
            end
            for (int i = 0; i < N; i++) begin
                q = (e[i] * (1 << (DW - 1))) / sum;
                exp_p[i] = (q > 32767) ? 32767 : q;
            end
        end
    endfunction

    task automatic check_outputs(input string name);
        check($sformatf("%s/argmax", name), argmax_idx, exp_i);
        for (int i = 0; i < N; i++)
            check($sformatf("%s/class%0d", name, i), softmax_out[i*DW +: DW], exp_p[i]);
    endtask

    task automatic start(input bit m);
        @(negedge clk);
        for (int i = 0; i < N; i++) logits[i*DW +: DW] = DW'(lg[i]);
        argmax_mode = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        logits = {5{$urandom()}};
        argmax_mode = ~m;
    endtask

    task automatic run_vec(input string name, input bit m, input bit bp);
        int lat;
        int want;
        check($sformatf("%s/in_ready_idle", name), in_ready, 1);
        model(m);
        start(m);
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
        end
        want = m ? N + 1 : 2 * N + N * (DW + 1);
        check($sformatf("%s/latency", name), lat, want);
        check_outputs(name);
        if (bp) begin
            in_valid = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1;
                logits = {5{$urandom()}};
                check($sformatf("%s/bp_valid", name), out_valid, 1);
                check($sformatf("%s/bp_in_ready", name), in_ready, 0);
                check_outputs($sformatf("%s/bp%0d", name, c));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("%s/valid_drop", name), out_valid, 0);
        check($sformatf("%s/in_ready_back", name), in_ready, 1);
        check($sformatf("%s/hold_argmax", name), argmax_idx, exp_i);
        check($sformatf("%s/hold_class0", name), softmax_out[DW-1:0], exp_p[0]);
        if (bp) begin
            @(posedge clk);
            #1;
            check($sformatf("%s/no_second_accept", name), in_ready, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r;
        int kind;
        bit m;
        #2 rst_n = 1'b0;
        #10;
        check("reset/in_ready", in_ready, 1);
        check("reset/out_valid", out_valid, 0);
        check("reset/argmax", argmax_idx, 0);
        check("reset/softmax", softmax_out == '0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) lg[i] = 0;
        run_vec("zeros", 1'b0, 1'b0);
        check("zeros/ccc", softmax_out[DW-1:0], 16'h0CCC);

        for (int i = 0; i < N; i++) lg[i] = (i == 7) ? 4096 : 0;
        run_vec("peak7", 1'b0, 1'b0);
        check("peak7/c7", softmax_out[7*DW +: DW], 10082);
        check("peak7/c0", softmax_out[0 +: DW], 2520);

        for (int i = 0; i < N; i++) lg[i] = (i == 3) ? 8192 : -8192;
        run_vec("sat3", 1'b0, 1'b0);
        check("sat3/c3", softmax_out[3*DW +: DW], 16'h7FFF);

        for (int i = 0; i < N; i++) lg[i] = (i == 2 || i == 5) ? 2048 : -4096;
        run_vec("argtie", 1'b1, 1'b0);
        check("argtie/idx", argmax_idx, 2);

        for (int i = 0; i < N; i++) lg[i] = $urandom_range(0, 4096) - 2048;
        run_vec("backpressure", 1'b0, 1'b1);

        for (int i = 0; i < N; i++) lg[i] = (i == 7) ? 4096 : 0;
        start(1'b0);
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset/out_valid", out_valid, 0);
        check("midreset/in_ready", in_ready, 1);
        check("midreset/softmax", softmax_out == '0, 1);
        check("midreset/argmax", argmax_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) lg[i] = 0;
        run_vec("zeros_after_reset", 1'b0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 2);
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                case (kind)
                    0: begin r = 16'($urandom()); lg[i] = int'($signed(r)); end
                    1: lg[i] = $urandom_range(0, 24576) - 12288;
                    default: lg[i] = ($urandom_range(0, 2) - 1) * 2048;
                endcase
            end
            run_vec($sformatf("rand%0d", t), m, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
